// File: rtl/grf_mp.sv
// Multi-port general register file: NRD combinational read ports with write bypass,
// two prioritised write ports, and a pending-write scoreboard for decode hazards.
module grf_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       wa0,
  input  logic [DATA_W-1:0]       wd0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       wa1,
  input  logic [DATA_W-1:0]       wd1,
  input  logic                    iss_valid,
  input  logic [ADDR_W-1:0]       iss_addr,
  input  logic                    clr_all,
  output logic [(1<<ADDR_W)-1:0]  busy_vec
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam bit          ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic              wv0;
  logic              wv1;

  assign wv0 = we0 && !(ZR && (wa0 == '0));
  assign wv1 = we1 && !(ZR && (wa1 == '0));

  // Port 1 is written last so it overrides port 0 on an address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wv0) regs[wa0] <= wd0;
      if (wv1) regs[wa1] <= wd1;
    end
  end

  always_comb begin
    busy_next = busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_all) begin
        busy_next[i] = 1'b0;
      end else if (iss_valid && (iss_addr == ADDR_W'(i))) begin
        busy_next[i] = 1'b1;
      end else if ((we0 && (wa0 == ADDR_W'(i))) || (we1 && (wa1 == ADDR_W'(i)))) begin
        busy_next[i] = 1'b0;
      end
    end
    if (ZR) busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign busy_vec = busy;

  // A write landing this cycle is bypassed, so the reader already has the final value.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              valid;
    logic              hit0;
    logic              hit1;

    assign a     = rd_addr[k*ADDR_W +: ADDR_W];
    assign valid = !(ZR && (a == '0));
    assign hit0  = we0 && (wa0 == a);
    assign hit1  = we1 && (wa1 == a);

    assign rd_data[k*DATA_W +: DATA_W] = !valid ? '0 :
                                         hit1   ? wd1 :
                                         hit0   ? wd0 : regs[a];
    assign rd_busy[k] = busy[a] && !(hit0 || hit1);
  end

endmodule

// File: tb/tb_grf_mp.sv
// Directed self-checking bench for grf_mp with default parameters (32x32, two read ports, r0 hardwired).
module tb_grf_mp;

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we0;
  logic [4:0]  wa0;
  logic [31:0] wd0;
  logic        we1;
  logic [4:0]  wa1;
  logic [31:0] wd1;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        clr_all;
  logic [31:0] busy_vec;

  int checks;
  int errors;

  grf_mp #(
    .DATA_W(32),
    .ADDR_W(5),
    .NRD(2),
    .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_busy(rd_busy),
    .we0(we0),
    .wa0(wa0),
    .wd0(wd0),
    .we1(we1),
    .wa1(wa1),
    .wd1(wd1),
    .iss_valid(iss_valid),
    .iss_addr(iss_addr),
    .clr_all(clr_all),
    .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    iss_valid = 1'b0; iss_addr = '0; clr_all = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    rd_addr = {5'd3, 5'd3};
    idle_inputs();

    #1;
    check_output("reset_rd_data", rd_data, 64'h0);
    check_output("reset_busy_vec", busy_vec, 64'h0);
    check_output("reset_rd_busy", rd_busy, 64'h0);

    @(negedge clk);
    reset = 1'b1;

    // Dual write to r3: port 1 wins, both in bypass and in the array.
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h22;
    rd_addr = {5'd3, 5'd3};
    #1;
    check_output("dual_bypass_p0", rd_data[31:0], 64'h22);
    check_output("dual_bypass_p1", rd_data[63:32], 64'h22);
    @(negedge clk);
    idle_inputs();
    #1;
    check_output("dual_stored", rd_data[31:0], 64'h22);

    // Write r5 with same-cycle read on port 1.
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    rd_addr = {5'd5, 5'd3};
    #1;
    check_output("bypass_p1", rd_data[63:32], 64'hDEADBEEF);
    check_output("no_bypass_p0", rd_data[31:0], 64'h22);
    @(negedge clk);
    idle_inputs();
    #1;
    check_output("stored_r5", rd_data[63:32], 64'hDEADBEEF);

    // r0 ignores writes and issues.
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_addr = 5'd0;
    rd_addr = {5'd0, 5'd0};
    #1;
    check_output("r0_bypass_zero", rd_data, 64'h0);
    @(negedge clk);
    idle_inputs();
    #1;
    check_output("r0_stored_zero", rd_data, 64'h0);
    check_output("r0_never_busy", busy_vec, 64'h0);

    // Issue r7, then clear it by a port 1 write.
    @(negedge clk);
    iss_valid = 1'b1; iss_addr = 5'd7;
    rd_addr = {5'd7, 5'd7};
    #1;
    check_output("iss7_not_yet", busy_vec, 64'h0);
    check_output("iss7_rd_busy_not_yet", rd_busy, 64'h0);
    @(negedge clk);
    idle_inputs();
    #1;
    check_output("iss7_busy_vec", busy_vec, 64'h80);
    check_output("iss7_rd_busy", rd_busy, 64'h3);
    @(negedge clk);
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h77;
    #1;
    check_output("wb7_rd_busy_bypass", rd_busy, 64'h0);
    check_output("wb7_data_bypass", rd_data[31:0], 64'h77);
    check_output("wb7_raw_still_set", busy_vec, 64'h80);
    @(negedge clk);
    idle_inputs();
    #1;
    check_output("wb7_cleared", busy_vec, 64'h0);
    check_output("wb7_rd_busy_clear", rd_busy, 64'h0);
    check_output("wb7_stored", rd_data[31:0], 64'h77);

    // Issue and write of r9 together: issue wins.
    @(negedge clk);
    iss_valid = 1'b1; iss_addr = 5'd9;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
    @(negedge clk);
    idle_inputs();
    #1;
    check_output("iss9_wins", busy_vec, 64'h200);
    @(negedge clk);
    iss_valid = 1'b1; iss_addr = 5'd12;
    @(negedge clk);
    idle_inputs();
    #1;
    check_output("iss12_added", busy_vec, 64'h1200);
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hAA;
    iss_valid = 1'b1; iss_addr = 5'd9;
    rd_addr = {5'd12, 5'd9};
    #1;
    check_output("reissue_rd_busy", rd_busy, 64'h2);
    check_output("reissue_data", rd_data[31:0], 64'hAA);
    @(negedge clk);
    idle_inputs();
    #1;
    check_output("reissue_raw", busy_vec, 64'h1200);
    @(negedge clk);
    clr_all = 1'b1; iss_valid = 1'b1; iss_addr = 5'd9;
    @(negedge clk);
    idle_inputs();
    #1;
    check_output("clr_all_wins", busy_vec, 64'h0);

    // Mid-run reset with a write in flight.
    @(negedge clk);
    iss_valid = 1'b1; iss_addr = 5'd4;
    @(negedge clk);
    idle_inputs();
    #1;
    check_output("pre_reset_busy", busy_vec, 64'h10);
    rd_addr = {5'd5, 5'd3};
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h55;
    #1;
    reset = 1'b0;
    #1;
    check_output("async_reset_busy", busy_vec, 64'h0);
    check_output("async_reset_r3", rd_data[31:0], 64'h0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    check_output("reset_write_lost", rd_data[63:32], 64'h0);
    check_output("reset_r3_cleared", rd_data[31:0], 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
